// File: rtl/txfifo_wr_arb_if.sv
// Bundle of requester, status and FIFO write-port signals for txfifo_wr_arb.
// The arbiter connects through the slave modport; the environment uses master.
interface txfifo_wr_arb_if #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned PTR   = 4
);
    logic             req0;
    logic             req1;
    logic [PTR:0]     len0;
    logic [PTR:0]     len1;
    logic             vld0;
    logic             vld1;
    logic [WIDTH-1:0] data0;
    logic [WIDTH-1:0] data1;
    logic             gnt0;
    logic             gnt1;
    logic             rdy0;
    logic             rdy1;
    logic             done0;
    logic             done1;
    logic             err;
    logic             busy;
    logic             fifo_wrreq;
    logic [WIDTH-1:0] fifo_data;
    logic             fifo_wrfull;
    logic [PTR:0]     fifo_wrusedw;

    modport slave (
        input  req0, req1, len0, len1, vld0, vld1, data0, data1,
        input  fifo_wrfull, fifo_wrusedw,
        output gnt0, gnt1, rdy0, rdy1, done0, done1, err, busy,
        output fifo_wrreq, fifo_data
    );

    modport master (
        output req0, req1, len0, len1, vld0, vld1, data0, data1,
        output fifo_wrfull, fifo_wrusedw,
        input  gnt0, gnt1, rdy0, rdy1, done0, done1, err, busy,
        input  fifo_wrreq, fifo_data
    );
endinterface

// File: rtl/txfifo_wr_arb.sv
// Round-robin write-port arbiter for the TX FIFO: admits whole packets only
// when the FIFO has room for all of them, so packets are never interleaved.
module txfifo_wr_arb #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned PTR   = 4
) (
    input  logic            wrclk,
    input  logic            aclr,
    txfifo_wr_arb_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CHECK, XFER, HOLD} state_t;

    localparam logic [PTR+1:0] DEPTH_W = (PTR+2)'(DEPTH);
    localparam logic [PTR:0]   ONE     = (PTR+1)'(1);

    state_t           state_q, state_d;
    logic             sel_q, sel_d;
    logic             last_q, last_d;
    logic             hold_q, hold_d;
    logic [PTR:0]     len_q, len_d;
    logic [PTR:0]     cnt_q, cnt_d;
    logic             fifo_wrreq_q, fifo_wrreq_d;
    logic [WIDTH-1:0] fifo_data_q, fifo_data_d;

    logic             win;
    logic [PTR+1:0]   used_w;
    logic [PTR+1:0]   free;
    logic             bad_len;
    logic             room;
    logic             vld_sel;
    logic [WIDTH-1:0] data_sel;
    logic             gnt_sel;
    logic             rdy_sel;
    logic             done_sel;
    logic             err_c;

    // Occupancy above DEPTH cannot come from a matching FIFO; clamp free at 0.
    always_comb begin
        used_w   = {1'b0, bus.fifo_wrusedw};
        free     = (used_w >= DEPTH_W) ? '0 : (DEPTH_W - used_w);
        bad_len  = (len_q == '0) || ({1'b0, len_q} > DEPTH_W);
        room     = (free >= {1'b0, len_q});
        win      = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
        vld_sel  = sel_q ? bus.vld1  : bus.vld0;
        data_sel = sel_q ? bus.data1 : bus.data0;
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        last_d   = last_q;
        hold_d   = hold_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        gnt_sel  = 1'b0;
        rdy_sel  = 1'b0;
        done_sel = 1'b0;
        err_c    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    sel_d   = win;
                    len_d   = win ? bus.len1 : bus.len0;
                    cnt_d   = '0;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (bad_len) begin
                    err_c    = 1'b1;
                    done_sel = 1'b1;
                    last_d   = sel_q;
                    hold_d   = 1'b0;
                    state_d  = HOLD;
                end else if (room) begin
                    state_d = XFER;
                end
            end
            XFER: begin
                gnt_sel = 1'b1;
                rdy_sel = vld_sel && !bus.fifo_wrfull;
                if (rdy_sel) begin
                    cnt_d = cnt_q + ONE;
                    if (cnt_q == len_q - ONE) begin
                        done_sel = 1'b1;
                        last_d   = sel_q;
                        hold_d   = 1'b0;
                        state_d  = HOLD;
                    end
                end
            end
            HOLD: begin
                // Two cycles: registered write, then the wrusedw update.
                if (hold_q) begin
                    hold_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    hold_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        fifo_wrreq_d = rdy_sel;
        fifo_data_d  = rdy_sel ? data_sel : fifo_data_q;
    end

    always_ff @(posedge wrclk) begin
        if (aclr) begin
            state_q      <= IDLE;
            sel_q        <= 1'b0;
            last_q       <= 1'b1;
            hold_q       <= 1'b0;
            len_q        <= '0;
            cnt_q        <= '0;
            fifo_wrreq_q <= 1'b0;
            fifo_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            last_q       <= last_d;
            hold_q       <= hold_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            fifo_wrreq_q <= fifo_wrreq_d;
            fifo_data_q  <= fifo_data_d;
        end
    end

    assign bus.gnt0       = gnt_sel  && !sel_q;
    assign bus.gnt1       = gnt_sel  &&  sel_q;
    assign bus.rdy0       = rdy_sel  && !sel_q;
    assign bus.rdy1       = rdy_sel  &&  sel_q;
    assign bus.done0      = done_sel && !sel_q;
    assign bus.done1      = done_sel &&  sel_q;
    assign bus.err        = err_c;
    assign bus.busy       = (state_q != IDLE);
    assign bus.fifo_wrreq = fifo_wrreq_q;
    assign bus.fifo_data  = fifo_data_q;
endmodule

// File: tb/tb_txfifo_wr_arb.sv
// Directed bench for txfifo_wr_arb: latency, round-robin order, space wait,
// illegal lengths, gaps/wrfull stalls and reset mid-packet.
module tb_txfifo_wr_arb;
    localparam int unsigned WIDTH = 64;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned PTR   = 4;

    logic wrclk = 1'b0;
    logic aclr  = 1'b1;

    txfifo_wr_arb_if #(.WIDTH(WIDTH), .PTR(PTR)) bus ();

    txfifo_wr_arb #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PTR(PTR)) dut (
        .wrclk (wrclk),
        .aclr  (aclr),
        .bus   (bus.slave)
    );

    always #5 wrclk = ~wrclk;

    int unsigned      n_checks = 0;
    int unsigned      n_errors = 0;
    logic [WIDTH-1:0] wq[$];
    logic [WIDTH-1:0] base0 = '0;
    logic [WIDTH-1:0] base1 = '0;
    int unsigned      acc0 = 0;
    int unsigned      acc1 = 0;
    logic             prev_rdy = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Samples the write port and rdy mid-cycle, then advances one clock and
    // presents the next data word of each requester.
    task automatic cycle();
        @(negedge wrclk);
        if (bus.fifo_wrreq === 1'b1) wq.push_back(bus.fifo_data);
        check("wrreq_follows_rdy", 64'(bus.fifo_wrreq), 64'(prev_rdy));
        prev_rdy = (bus.rdy0 | bus.rdy1) & ~aclr;
        if (bus.rdy0 && !aclr) acc0++;
        if (bus.rdy1 && !aclr) acc1++;
        @(posedge wrclk);
        #1;
        bus.data0 = base0 + 64'(acc0);
        bus.data1 = base1 + 64'(acc1);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic start0(input logic [PTR:0] len, input logic [WIDTH-1:0] base);
        base0 = base; acc0 = 0; bus.data0 = base;
        bus.len0 = len; bus.vld0 = 1'b1; bus.req0 = 1'b1;
    endtask

    task automatic start1(input logic [PTR:0] len, input logic [WIDTH-1:0] base);
        base1 = base; acc1 = 0; bus.data1 = base;
        bus.len1 = len; bus.vld1 = 1'b1; bus.req1 = 1'b1;
    endtask

    task automatic expect_writes(input string tag, input logic [WIDTH-1:0] base, input int unsigned n);
        check({tag, "_count"}, 64'(wq.size()), 64'(n));
        for (int i = 0; i < int'(n) && i < wq.size(); i++)
            check($sformatf("%s_w%0d", tag, i), wq[i], base + 64'(i));
    endtask

    logic [WIDTH-1:0] exp_cont[8];

    initial begin
        bus.req0 = 0; bus.req1 = 0; bus.len0 = '0; bus.len1 = '0;
        bus.vld0 = 0; bus.vld1 = 0; bus.data0 = '0; bus.data1 = '0;
        bus.fifo_wrfull = 0; bus.fifo_wrusedw = '0;

        // Reset state
        @(posedge wrclk); #1;
        @(posedge wrclk); #1;
        settle();
        check("rst_busy", 64'(bus.busy), 0);
        check("rst_gnt", 64'({bus.gnt0, bus.gnt1}), 0);
        check("rst_rdy", 64'({bus.rdy0, bus.rdy1}), 0);
        check("rst_done_err", 64'({bus.done0, bus.done1, bus.err}), 0);
        check("rst_wrreq", 64'(bus.fifo_wrreq), 0);
        check("rst_data", bus.fifo_data, 0);
        aclr = 0;

        // Single packet, len 4, empty FIFO
        wq.delete();
        start0(5'd4, 64'h1000);
        cycle(); settle();
        check("sp_check_busy", 64'(bus.busy), 1);
        check("sp_check_gnt", 64'(bus.gnt0), 0);
        cycle(); settle();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("sp_gnt%0d", i), 64'(bus.gnt0), 1);
            check($sformatf("sp_rdy%0d", i), 64'(bus.rdy0), 1);
            check($sformatf("sp_done%0d", i), 64'(bus.done0), (i == 3) ? 64'd1 : 64'd0);
            check($sformatf("sp_gnt1_%0d", i), 64'(bus.gnt1), 0);
            cycle(); settle();
        end
        bus.req0 = 0; bus.vld0 = 0;
        check("sp_hold_gnt", 64'(bus.gnt0), 0);
        check("sp_hold_busy", 64'(bus.busy), 1);
        cycle(); settle();
        check("sp_hold2_busy", 64'(bus.busy), 1);
        cycle(); settle();
        check("sp_idle_busy", 64'(bus.busy), 0);
        expect_writes("sp", 64'h1000, 4);

        // Contention from reset: order 0,1,0,1
        aclr = 1; cycle(); aclr = 0; settle();
        wq.delete();
        start0(5'd2, 64'h2000);
        start1(5'd2, 64'h3000);
        for (int p = 0; p < 4; p++) begin
            int unsigned w;
            w = 0;
            while (!(bus.gnt0 || bus.gnt1) && w < 10) begin
                cycle(); settle(); w++;
            end
            check($sformatf("ct_timeout%0d", p), 64'(w >= 10), 0);
            check($sformatf("ct_gnt0_%0d", p), 64'(bus.gnt0), ((p % 2) == 0) ? 64'd1 : 64'd0);
            check($sformatf("ct_gnt1_%0d", p), 64'(bus.gnt1), ((p % 2) == 1) ? 64'd1 : 64'd0);
            for (int i = 0; i < 2; i++) begin
                if ((p % 2) == 0) begin
                    check($sformatf("ct_rdy_other%0d_%0d", p, i), 64'(bus.rdy1 | bus.done1), 0);
                    check($sformatf("ct_done%0d_%0d", p, i), 64'(bus.done0), 64'(i == 1));
                end else begin
                    check($sformatf("ct_rdy_other%0d_%0d", p, i), 64'(bus.rdy0 | bus.done0), 0);
                    check($sformatf("ct_done%0d_%0d", p, i), 64'(bus.done1), 64'(i == 1));
                end
                cycle(); settle();
            end
        end
        bus.req0 = 0; bus.req1 = 0; bus.vld0 = 0; bus.vld1 = 0;
        cycle(); cycle(); settle();
        check("ct_idle", 64'(bus.busy), 0);
        exp_cont = '{64'h2000, 64'h2001, 64'h3000, 64'h3001,
                     64'h2002, 64'h2003, 64'h3002, 64'h3003};
        check("ct_count", 64'(wq.size()), 8);
        for (int i = 0; i < 8 && i < wq.size(); i++)
            check($sformatf("ct_w%0d", i), wq[i], exp_cont[i]);

        // Space wait: 3 free words for a 5-word packet
        wq.delete();
        bus.fifo_wrusedw = 5'd13;
        start1(5'd5, 64'h5000);
        for (int i = 0; i < 4; i++) begin
            cycle(); settle();
            check($sformatf("sw_wait_gnt%0d", i), 64'(bus.gnt1), 0);
            check($sformatf("sw_wait_busy%0d", i), 64'(bus.busy), 1);
        end
        bus.fifo_wrusedw = 5'd11;
        settle();
        check("sw_still_wait", 64'(bus.gnt1), 0);
        cycle(); settle();
        check("sw_gnt", 64'(bus.gnt1), 1);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("sw_done%0d", i), 64'(bus.done1), 64'(i == 4));
            cycle(); settle();
        end
        bus.req1 = 0; bus.vld1 = 0; bus.fifo_wrusedw = '0;
        cycle(); cycle(); settle();
        check("sw_idle", 64'(bus.busy), 0);
        expect_writes("sw", 64'h5000, 5);

        // Illegal lengths 0 and 17
        wq.delete();
        for (int k = 0; k < 2; k++) begin
            start0((k == 0) ? 5'd0 : 5'd17, 64'h4000);
            cycle(); settle();
            check($sformatf("il_err%0d", k), 64'(bus.err), 1);
            check($sformatf("il_done%0d", k), 64'(bus.done0), 1);
            check($sformatf("il_gnt%0d", k), 64'(bus.gnt0), 0);
            cycle(); settle();
            bus.req0 = 0; bus.vld0 = 0;
            check($sformatf("il_err_gone%0d", k), 64'({bus.err, bus.done0}), 0);
            check($sformatf("il_hold%0d", k), 64'(bus.busy), 1);
            cycle(); settle();
            check($sformatf("il_hold2_%0d", k), 64'(bus.busy), 1);
            cycle(); settle();
            check($sformatf("il_idle%0d", k), 64'(bus.busy), 0);
        end
        check("il_no_writes", 64'(wq.size()), 0);

        // Gaps in vld: 1,0,1,1 with len 3
        wq.delete();
        start0(5'd3, 64'h6000);
        cycle(); cycle(); settle();
        check("gp_rdy_a", 64'(bus.rdy0), 1);
        cycle(); bus.vld0 = 0; settle();
        check("gp_gap_rdy", 64'(bus.rdy0), 0);
        check("gp_gap_gnt", 64'(bus.gnt0), 1);
        cycle(); bus.vld0 = 1; settle();
        check("gp_rdy_b", 64'(bus.rdy0), 1);
        check("gp_done_b", 64'(bus.done0), 0);
        cycle(); settle();
        check("gp_done_c", 64'(bus.done0), 1);
        cycle(); bus.req0 = 0; bus.vld0 = 0;
        cycle(); cycle(); settle();
        check("gp_idle", 64'(bus.busy), 0);
        expect_writes("gp", 64'h6000, 3);

        // wrfull asserted mid-packet
        wq.delete();
        start0(5'd3, 64'h6100);
        cycle(); cycle(); settle();
        check("wf_rdy_a", 64'(bus.rdy0), 1);
        cycle(); bus.fifo_wrfull = 1; settle();
        check("wf_full_rdy", 64'(bus.rdy0), 0);
        check("wf_full_gnt", 64'(bus.gnt0), 1);
        cycle(); settle();
        check("wf_full_rdy2", 64'(bus.rdy0), 0);
        cycle(); bus.fifo_wrfull = 0; settle();
        check("wf_rdy_b", 64'(bus.rdy0), 1);
        check("wf_done_b", 64'(bus.done0), 0);
        cycle(); settle();
        check("wf_done_c", 64'(bus.done0), 1);
        cycle(); bus.req0 = 0; bus.vld0 = 0;
        cycle(); cycle(); settle();
        expect_writes("wf", 64'h6100, 3);

        // Reset after 2 of 8 words, then req1 alone
        wq.delete();
        start0(5'd8, 64'h7000);
        cycle(); cycle(); cycle(); cycle(); settle();
        check("rm_rdy_before", 64'(bus.rdy0), 1);
        aclr = 1; bus.req0 = 0; bus.vld0 = 0;
        cycle(); aclr = 0; settle();
        check("rm_busy", 64'(bus.busy), 0);
        check("rm_gnt_rdy", 64'({bus.gnt0, bus.gnt1, bus.rdy0, bus.rdy1}), 0);
        check("rm_done_err", 64'({bus.done0, bus.done1, bus.err}), 0);
        check("rm_wrreq", 64'(bus.fifo_wrreq), 0);
        check("rm_data", bus.fifo_data, 0);
        expect_writes("rm_pkt0", 64'h7000, 2);
        wq.delete();
        start1(5'd2, 64'h8000);
        cycle(); cycle(); settle();
        check("rm_gnt1", 64'(bus.gnt1), 1);
        check("rm_gnt0", 64'(bus.gnt0), 0);
        cycle(); settle();
        check("rm_done1", 64'(bus.done1), 1);
        cycle(); bus.req1 = 0; bus.vld1 = 0;
        cycle(); cycle(); settle();
        check("rm_idle", 64'(bus.busy), 0);
        expect_writes("rm_pkt1", 64'h8000, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
